// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider producing {HI, LO} = {remainder, quotient}.
// Stalls the pipeline through the iterations and pulses ready for one cycle with the result.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               sign,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted only in IDLE without annul; ready is a one-cycle
  // pulse and result is valid exactly in that cycle, then held until the next completion.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] opa_raw;
  logic             sign_q;
  logic             rem_sign;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // The compare is WIDTH+1 bits wide; when it succeeds the true difference is
  // below the divisor, so the truncated WIDTH-bit subtraction is exact.
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvsr});
  assign diff    = shifted[WIDTH-1:0] - dvsr;
  assign q_fix   = sign_q   ? -quo : quo;
  assign r_fix   = rem_sign ? -rem : rem;

  assign busy = (state == ST_ON) || (state == ST_DIVZERO) || (state == ST_END) ||
                ((state == ST_IDLE) && start && !annul);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      opa_raw  <= '0;
      sign_q   <= 1'b0;
      rem_sign <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !annul) begin
            opa_raw <= opa;
            cnt     <= '0;
            rem     <= '0;
            if (opb == '0) begin
              state <= ST_DIVZERO;
            end else begin
              state    <= ST_ON;
              quo      <= (sign && opa[WIDTH-1]) ? -opa : opa;
              dvsr     <= (sign && opb[WIDTH-1]) ? -opb : opb;
              sign_q   <= sign & (opa[WIDTH-1] ^ opb[WIDTH-1]);
              rem_sign <= sign & opa[WIDTH-1];
            end
          end
        end
        ST_ON: begin
          if (annul) begin
            state <= ST_IDLE;
          end else begin
            rem <= fits ? diff : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_END;
          end
        end
        ST_END: begin
          result <= {r_fix, q_fix};
          ready  <= 1'b1;
          state  <= ST_IDLE;
        end
        ST_DIVZERO: begin
          if (annul) begin
            state <= ST_IDLE;
          end else begin
            result <= {opa_raw, {WIDTH{1'b1}}};
            ready  <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
